// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared types and constants for the LC-3 memory controller: FSM states,
// device-register addresses, register select codes and status bit positions.
package lc3_mem_pkg;

   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_e;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_KBSR,
      SEL_KBDR,
      SEL_DSR,
      SEL_DDR
   } sel_e;

   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;

   localparam int unsigned READY_BIT = 15;
   localparam int unsigned IE_BIT    = 14;

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// Datapath-side memory bus (MAR/MDR/MIO_EN/R.W plus the R completion pulse).
interface lc3_mem_ctrl_if;
   import lc3_mem_pkg::*;

   logic              req;
   logic              we;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   modport master (output req, we, addr, wdata, input rdata, ready);
   modport slave  (input req, we, addr, wdata, output rdata, ready);

endinterface

// File: rtl/lc3_mem_ctrl_mmio_regs.sv
// KBSR/KBDR/DSR device registers, keyboard and display handshakes, interrupts.
module lc3_mmio_regs
   import lc3_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  sel_e        sel_i,
   input  logic        rd_stb_i,
   input  logic        wr_stb_i,
   input  logic [15:0] wdata_i,
   output logic [15:0] rdata_o,
   input  logic        kbd_valid_i,
   input  logic [7:0]  kbd_data_i,
   output logic        kbd_ready_o,
   output logic        dsp_valid_o,
   output logic [7:0]  dsp_data_o,
   input  logic        dsp_ready_i,
   output logic        kbd_irq_o,
   output logic        dsp_irq_o
);

   logic       kb_rdy_q, kb_rdy_d;
   logic       kb_ie_q, kb_ie_d;
   logic [7:0] kbdr_q, kbdr_d;
   logic       ds_rdy_q, ds_rdy_d;
   logic       ds_ie_q, ds_ie_d;
   logic       dsp_valid_q, dsp_valid_d;
   logic [7:0] dsp_data_q, dsp_data_d;
   logic       unused_wdata;

   assign unused_wdata = ^{wdata_i[15], wdata_i[13:8]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         kb_rdy_q    <= 1'b0;
         kb_ie_q     <= 1'b0;
         kbdr_q      <= '0;
         ds_rdy_q    <= 1'b1;
         ds_ie_q     <= 1'b0;
         dsp_valid_q <= 1'b0;
         dsp_data_q  <= '0;
      end else begin
         kb_rdy_q    <= kb_rdy_d;
         kb_ie_q     <= kb_ie_d;
         kbdr_q      <= kbdr_d;
         ds_rdy_q    <= ds_rdy_d;
         ds_ie_q     <= ds_ie_d;
         dsp_valid_q <= dsp_valid_d;
         dsp_data_q  <= dsp_data_d;
      end
   end

   always_comb begin
      kb_rdy_d    = kb_rdy_q;
      kb_ie_d     = kb_ie_q;
      kbdr_d      = kbdr_q;
      ds_rdy_d    = ds_rdy_q;
      ds_ie_d     = ds_ie_q;
      dsp_valid_d = dsp_valid_q;
      dsp_data_d  = dsp_data_q;

      // Clear first so a same-cycle keyboard load overrides it.
      if (rd_stb_i && sel_i == SEL_KBDR) kb_rdy_d = 1'b0;
      if (kbd_valid_i && !kb_rdy_q) begin
         kb_rdy_d = 1'b1;
         kbdr_d   = kbd_data_i;
      end

      if (wr_stb_i) begin
         case (sel_i)
            SEL_KBSR: kb_ie_d = wdata_i[IE_BIT];
            SEL_DSR:  ds_ie_d = wdata_i[IE_BIT];
            SEL_DDR: begin
               if (ds_rdy_q) begin
                  dsp_valid_d = 1'b1;
                  dsp_data_d  = wdata_i[7:0];
                  ds_rdy_d    = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // A char is pending only while DSR ready is low, so this cannot collide with a DDR write.
      if (dsp_valid_q && dsp_ready_i) begin
         dsp_valid_d = 1'b0;
         ds_rdy_d    = 1'b1;
      end
   end

   always_comb begin
      rdata_o = '0;
      case (sel_i)
         SEL_KBSR: begin
            rdata_o[READY_BIT] = kb_rdy_q;
            rdata_o[IE_BIT]    = kb_ie_q;
         end
         SEL_KBDR: rdata_o = {8'h00, kbdr_q};
         SEL_DSR: begin
            rdata_o[READY_BIT] = ds_rdy_q;
            rdata_o[IE_BIT]    = ds_ie_q;
         end
         default: ;
      endcase
   end

   assign kbd_ready_o = ~kb_rdy_q;
   assign dsp_valid_o = dsp_valid_q;
   assign dsp_data_o  = dsp_data_q;
   assign kbd_irq_o   = kb_rdy_q & kb_ie_q;
   assign dsp_irq_o   = ds_rdy_q & ds_ie_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-side controller: request FSM, address decode, block-RAM port
// and read-data mux; device registers live in lc3_mmio_regs.
module lc3_mem_ctrl
   import lc3_mem_pkg::*;
#(
   parameter int unsigned ADDR = 12,
   parameter int unsigned DATA = 16
)
(
   input  logic            clk,
   input  logic            rst_n,
   lc3_mem_ctrl_if.slave   bus,
   output logic            mem_wr,
   output logic [ADDR-1:0] mem_addr,
   output logic [DATA-1:0] mem_din,
   input  logic [DATA-1:0] mem_dout,
   input  logic            kbd_valid,
   input  logic [7:0]      kbd_data,
   output logic            kbd_ready,
   output logic            dsp_valid,
   output logic [7:0]      dsp_data,
   input  logic            dsp_ready,
   output logic            kbd_irq,
   output logic            dsp_irq
);

   state_e          state_q, state_d;
   logic [15:0]     addr_q, addr_d;
   logic            we_q, we_d;
   logic [DATA-1:0] wdata_q, wdata_d;
   logic            resp;
   logic            ram_hit;
   sel_e            sel;
   logic [15:0]     reg_rdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      resp    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               state_d = ST_ACCESS;
               addr_d  = bus.addr;
               we_d    = bus.we;
               wdata_d = bus.wdata;
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP: begin
            state_d = ST_IDLE;
            resp    = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ram_hit = (addr_q[15:ADDR] == '0);

   always_comb begin
      sel = SEL_NONE;
      if (ram_hit) begin
         sel = SEL_RAM;
      end else begin
         case (addr_q)
            KBSR_ADDR: sel = SEL_KBSR;
            KBDR_ADDR: sel = SEL_KBDR;
            DSR_ADDR:  sel = SEL_DSR;
            DDR_ADDR:  sel = SEL_DDR;
            default:   sel = SEL_NONE;
         endcase
      end
   end

   assign mem_wr   = (state_q == ST_ACCESS) & we_q & ram_hit & rst_n;
   assign mem_addr = addr_q[ADDR-1:0];
   assign mem_din  = wdata_q;

   assign bus.ready = resp;

   always_comb begin
      bus.rdata = '0;
      if (resp && !we_q) begin
         bus.rdata = (sel == SEL_RAM) ? mem_dout : reg_rdata;
      end
   end

   lc3_mmio_regs u_regs (
      .clk         (clk),
      .rst_n       (rst_n),
      .sel_i       (sel),
      .rd_stb_i    (resp & ~we_q),
      .wr_stb_i    (resp & we_q),
      .wdata_i     (wdata_q),
      .rdata_o     (reg_rdata),
      .kbd_valid_i (kbd_valid),
      .kbd_data_i  (kbd_data),
      .kbd_ready_o (kbd_ready),
      .dsp_valid_o (dsp_valid),
      .dsp_data_o  (dsp_data),
      .dsp_ready_i (dsp_ready),
      .kbd_irq_o   (kbd_irq),
      .dsp_irq_o   (dsp_irq)
   );

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: behavioural RAM, transaction-level reference model
// checked every cycle, plus directed accesses with hand-computed results.
module tb_lc3_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_wr;
   logic [11:0] mem_addr;
   logic [15:0] mem_din;
   logic [15:0] mem_dout = 16'h0000;
   logic        kbd_valid = 1'b0;
   logic [7:0]  kbd_data = 8'h00;
   logic        kbd_ready;
   logic        dsp_valid;
   logic [7:0]  dsp_data;
   logic        dsp_ready = 1'b0;
   logic        kbd_irq, dsp_irq;

   int tests = 0;
   int fails = 0;

   lc3_mem_ctrl_if bus();

   lc3_mem_ctrl #(.ADDR(12), .DATA(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .kbd_valid (kbd_valid),
      .kbd_data  (kbd_data),
      .kbd_ready (kbd_ready),
      .dsp_valid (dsp_valid),
      .dsp_data  (dsp_data),
      .dsp_ready (dsp_ready),
      .kbd_irq   (kbd_irq),
      .dsp_irq   (dsp_irq)
   );

   always #5 clk = ~clk;

   // Single-port block RAM, registered read, write-first.
   logic [15:0] ram [0:4095];
   always @(posedge clk) begin
      if (mem_wr) begin
         ram[mem_addr] <= mem_din;
         mem_dout      <= mem_din;
      end else begin
         mem_dout <= ram[mem_addr];
      end
   end

   // Reference model: transaction phase (0 idle, 1 access, 2 response) and device state.
   logic [15:0] m_ram [0:4095];
   int          m_ph = 0;
   logic        t_we = 1'b0;
   logic [15:0] t_addr = 16'h0000, t_wdata = 16'h0000;
   logic        kb_full = 1'b0, kb_ie = 1'b0, ds_ie = 1'b0, dsp_busy = 1'b0;
   logic [7:0]  kb_char = 8'h00, dsp_char = 8'h00;

   function automatic logic [15:0] exp_read();
      if (t_addr < 16'h1000) return m_ram[t_addr[11:0]];
      case (t_addr)
         16'hFE00: return {kb_full, kb_ie, 14'h0};
         16'hFE02: return {8'h00, kb_char};
         16'hFE04: return {~dsp_busy, ds_ie, 14'h0};
         default:  return 16'h0000;
      endcase
   endfunction

   always @(posedge clk) begin
      logic old_busy, old_full;
      if (!rst_n) begin
         m_ph = 0; kb_full = 0; kb_ie = 0; ds_ie = 0;
         dsp_busy = 0; kb_char = 8'h00; dsp_char = 8'h00;
      end else begin
         old_busy = dsp_busy;
         old_full = kb_full;
         if (m_ph == 1 && t_we && t_addr < 16'h1000) m_ram[t_addr[11:0]] = t_wdata;
         if (m_ph == 2) begin
            if (t_we) begin
               if (t_addr == 16'hFE00) kb_ie = t_wdata[14];
               if (t_addr == 16'hFE04) ds_ie = t_wdata[14];
               if (t_addr == 16'hFE06 && !old_busy) begin
                  dsp_busy = 1'b1;
                  dsp_char = t_wdata[7:0];
               end
            end else if (t_addr == 16'hFE02) begin
               kb_full = 1'b0;
            end
         end
         if (old_busy && dsp_ready) dsp_busy = 1'b0;
         if (kbd_valid && !old_full) begin
            kb_full = 1'b1;
            kb_char = kbd_data;
         end
         if (m_ph == 0) begin
            if (bus.req) begin
               t_we = bus.we; t_addr = bus.addr; t_wdata = bus.wdata;
               m_ph = 1;
            end
         end else begin
            m_ph = (m_ph == 1) ? 2 : 0;
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("ready", {15'h0, bus.ready}, {15'h0, m_ph == 2});
      chk("rdata", bus.rdata, (m_ph == 2 && !t_we) ? exp_read() : 16'h0000);
      chk("mem_wr", {15'h0, mem_wr},
          {15'h0, m_ph == 1 && t_we && t_addr < 16'h1000 && rst_n});
      if (m_ph != 0) chk("mem_addr", {4'h0, mem_addr}, {4'h0, t_addr[11:0]});
      chk("kbd_ready", {15'h0, kbd_ready}, {15'h0, ~kb_full});
      chk("dsp_valid", {15'h0, dsp_valid}, {15'h0, dsp_busy});
      chk("dsp_data", {8'h0, dsp_data}, {8'h0, dsp_char});
      chk("kbd_irq", {15'h0, kbd_irq}, {15'h0, kb_full & kb_ie});
      chk("dsp_irq", {15'h0, dsp_irq}, {15'h0, ~dsp_busy & ds_ie});
   end

   task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic exp_wr, input logic [15:0] exp_rd, input logic kbd_resp);
      int  n = 0;
      bit  got = 0;
      @(negedge clk); #1;
      bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
      while (!got && n < 6) begin
         @(negedge clk);
         n++;
         if (n == 1) chk("acc_mem_wr", {15'h0, mem_wr}, {15'h0, exp_wr});
         if (bus.ready) got = 1;
      end
      if (!got) begin
         chk("ready_timeout", 16'h0000, 16'h0001);
      end else begin
         chk("latency", n[15:0], 16'd2);
         if (!w) chk("acc_rdata", bus.rdata, exp_rd);
      end
      #1;
      bus.req = 1'b0;
      if (kbd_resp) begin
         kbd_valid = 1'b1; kbd_data = 8'h42;
         @(negedge clk); #1;
         kbd_valid = 1'b0;
      end
   endtask

   task automatic kbd_send(input logic [7:0] c);
      @(negedge clk); #1;
      kbd_valid = 1'b1; kbd_data = c;
      @(negedge clk); #1;
      kbd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram[i]   = 16'h0000;
         m_ram[i] = 16'h0000;
      end
      bus.req = 1'b0; bus.we = 1'b0; bus.addr = 16'h0000; bus.wdata = 16'h0000;
      repeat (2) @(negedge clk);
      chk("rst_ready", {15'h0, bus.ready}, 16'h0000);
      chk("rst_rdata", bus.rdata, 16'h0000);
      chk("rst_kbd_ready", {15'h0, kbd_ready}, 16'h0001);
      chk("rst_dsp_data", {8'h0, dsp_data}, 16'h0000);
      #1 rst_n = 1'b1;

      // RAM write/read, top of RAM, unmapped space
      access(1, 16'h0010, 16'h1234, 1, 16'h0, 0);
      access(0, 16'h0010, 16'h0000, 0, 16'h1234, 0);
      access(1, 16'h0FFF, 16'hABCD, 1, 16'h0, 0);
      access(0, 16'h0FFF, 16'h0000, 0, 16'hABCD, 0);
      access(0, 16'h1000, 16'h0000, 0, 16'h0000, 0);
      access(0, 16'hFE08, 16'h0000, 0, 16'h0000, 0);
      access(1, 16'h3000, 16'h5555, 0, 16'h0, 0);
      access(0, 16'h0000, 16'h0000, 0, 16'h0000, 0);

      // Keyboard path
      kbd_send(8'h41);
      @(negedge clk);
      chk("kbd_ready_full", {15'h0, kbd_ready}, 16'h0000);
      access(0, 16'hFE00, 16'h0, 0, 16'h8000, 0);
      access(1, 16'hFE02, 16'h00FF, 0, 16'h0, 0);
      access(0, 16'hFE02, 16'h0, 0, 16'h0041, 0);
      access(0, 16'hFE00, 16'h0, 0, 16'h0000, 0);
      access(0, 16'hFE02, 16'h0, 0, 16'h0041, 1);
      access(0, 16'hFE00, 16'h0, 0, 16'h8000, 0);
      access(0, 16'hFE02, 16'h0, 0, 16'h0042, 0);
      access(0, 16'hFE00, 16'h0, 0, 16'h0000, 0);

      // Display path
      access(1, 16'hFE06, 16'h0058, 0, 16'h0, 0);
      @(negedge clk);
      chk("dsp_valid_set", {15'h0, dsp_valid}, 16'h0001);
      chk("dsp_data_58", {8'h0, dsp_data}, 16'h0058);
      access(0, 16'hFE04, 16'h0, 0, 16'h0000, 0);
      access(1, 16'hFE06, 16'h0077, 0, 16'h0, 0);
      @(negedge clk);
      chk("dsp_data_kept", {8'h0, dsp_data}, 16'h0058);
      #1 dsp_ready = 1'b1;
      @(negedge clk);
      chk("dsp_valid_drop", {15'h0, dsp_valid}, 16'h0000);
      #1 dsp_ready = 1'b0;
      access(0, 16'hFE04, 16'h0, 0, 16'h8000, 0);

      // Interrupt enables; only bit14 is writable
      access(1, 16'hFE00, 16'hFFFF, 0, 16'h0, 0);
      access(0, 16'hFE00, 16'h0, 0, 16'h4000, 0);
      kbd_send(8'h43);
      @(negedge clk);
      chk("kbd_irq_set", {15'h0, kbd_irq}, 16'h0001);
      access(0, 16'hFE02, 16'h0, 0, 16'h0043, 0);
      @(negedge clk);
      chk("kbd_irq_clr", {15'h0, kbd_irq}, 16'h0000);
      access(1, 16'hFE04, 16'h4000, 0, 16'h0, 0);
      access(0, 16'hFE04, 16'h0, 0, 16'hC000, 0);
      @(negedge clk);
      chk("dsp_irq_set", {15'h0, dsp_irq}, 16'h0001);

      // Reset during ACCESS of a RAM write, with a display char pending
      access(1, 16'h0020, 16'h1111, 1, 16'h0, 0);
      access(1, 16'hFE06, 16'h0055, 0, 16'h0, 0);
      @(negedge clk); #1;
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0020; bus.wdata = 16'h2222;
      @(negedge clk);
      chk("pre_rst_mem_wr", {15'h0, mem_wr}, 16'h0001);
      #1 rst_n = 1'b0; bus.req = 1'b0;
      #1 chk("rst_gates_mem_wr", {15'h0, mem_wr}, 16'h0000);
      @(negedge clk);
      chk("rst2_ready", {15'h0, bus.ready}, 16'h0000);
      chk("rst2_dsp_valid", {15'h0, dsp_valid}, 16'h0000);
      chk("rst2_kbd_ready", {15'h0, kbd_ready}, 16'h0001);
      chk("rst2_dsp_irq", {15'h0, dsp_irq}, 16'h0000);
      #1 rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_no_ready", {15'h0, bus.ready}, 16'h0000);
      end
      access(0, 16'h0020, 16'h0, 0, 16'h1111, 0);
      access(0, 16'hFE04, 16'h0, 0, 16'h8000, 0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
